// File: rtl/exe_pkg.sv
// Shared opcode/state types and status-flag layout for the exe_unit_w2 execution unit.
package exe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SLT = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;
    localparam int ST_E = 3;

    function automatic logic [3:0] pack_status(input logic z, input logic neg,
                                               input logic v, input logic e);
        logic [3:0] s;
        s       = '0;
        s[ST_Z] = z;
        s[ST_N] = neg;
        s[ST_V] = v;
        s[ST_E] = e;
        return s;
    endfunction

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, m cycles per operation.
// done is high during the last step; product then already includes that final step.
module exe_mul_seq
    import exe_pkg::*;
#(
    parameter int m = 8
) (
    input  logic           i_clk,
    input  logic           i_rsn,
    input  logic           start,
    input  logic [m-1:0]   arg_a,
    input  logic [m-1:0]   arg_b,
    output logic           done,
    output logic [2*m-1:0] product
);

    localparam int CW = (m > 1) ? $clog2(m) : 1;

    logic           busy;
    logic [CW-1:0]  step;
    logic [2*m-1:0] acc;
    logic [2*m-1:0] acc_next;
    logic [2*m-1:0] mcand;
    logic [m-1:0]   mplier;

    // NOTE: every variable in always_comb gets a default first so no latch is inferred.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = busy && (step == CW'(m - 1));
    assign product = acc_next;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            busy   <= 1'b0;
            step   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            step   <= '0;
            acc    <= '0;
            mcand  <= {{m{1'b0}}, arg_a};
            mplier <= arg_b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_unit_w2.sv
// Valid/ready execution unit: single-cycle ALU ops plus an optional multi-cycle multiplier.
// Define EXE_UNIT_W2_MUL_EN to build the multiplier; otherwise MUL reports E=1 with a zero result.
module exe_unit_w2
    import exe_pkg::*;
#(
    parameter int m = 8,
    parameter int n = 3
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [n-1:0] i_oper,
    input  logic [m-1:0] i_argA,
    input  logic [m-1:0] i_argB,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [m-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam logic [m-1:0] M_W = m[m-1:0];

    state_e         state;
    state_e         state_nxt;
    op_e            op;
    logic           accept;
    logic           start_mul;
    logic           mul_done;
    logic [2*m-1:0] mul_prod;
    logic [m-1:0]   alu_res;
    logic [m-1:0]   shamt;
    logic           alu_v;
    logic           alu_e;
    logic [3:0]     alu_status;

`ifdef EXE_UNIT_W2_MUL_EN
    localparam bit MUL_EN = 1'b1;

    exe_mul_seq #(.m(m)) u_mul (
        .i_clk   (i_clk),
        .i_rsn   (i_rsn),
        .start   (start_mul),
        .arg_a   (i_argA),
        .arg_b   (i_argB),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    localparam bit MUL_EN = 1'b0;

    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    assign op        = op_e'(i_oper);
    assign o_ready   = (state == IDLE) || ((state == DONE) && i_ready);
    assign o_valid   = (state == DONE);
    assign accept    = i_valid && o_ready;
    assign start_mul = accept && (op == OP_MUL) && MUL_EN;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        shamt   = i_argB % M_W;
        case (op)
            OP_ADD: begin
                alu_res = i_argA + i_argB;
                alu_v   = (i_argA[m-1] == i_argB[m-1]) && (alu_res[m-1] != i_argA[m-1]);
            end
            OP_SUB: begin
                alu_res = i_argA - i_argB;
                alu_v   = (i_argA[m-1] != i_argB[m-1]) && (alu_res[m-1] != i_argA[m-1]);
            end
            OP_AND:  alu_res = i_argA & i_argB;
            OP_OR:   alu_res = i_argA | i_argB;
            OP_XOR:  alu_res = i_argA ^ i_argB;
            OP_SHL:  alu_res = i_argA << shamt;
            OP_SLT:  alu_res = {{(m-1){1'b0}}, ($signed(i_argA) < $signed(i_argB))};
            // Without the multiplier, MUL completes immediately and flags the error.
            OP_MUL:  alu_e   = ~MUL_EN;
            default: alu_res = '0;
        endcase
        alu_status = pack_status(alu_res == '0, alu_res[m-1], alu_v, alu_e);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = start_mul ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = start_mul ? BUSY : DONE;
                end else if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state    <= IDLE;
            o_result <= '0;
            o_status <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !start_mul) begin
                o_result <= alu_res;
                o_status <= alu_status;
            end else if (mul_done) begin
                o_result <= mul_prod[m-1:0];
                o_status <= pack_status(mul_prod[m-1:0] == '0, mul_prod[m-1],
                                        |mul_prod[2*m-1:m], 1'b0);
            end
        end
    end

endmodule

// File: tb/tb_exe_unit_w2.sv
// Directed bench for exe_unit_w2 (m=8): vector table plus hold, back-to-back and reset-abort sequences.
module tb_exe_unit_w2;

    localparam int M = 8;
`ifdef EXE_UNIT_W2_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SHL = 3'd5;
    localparam logic [2:0] SLT = 3'd6;
    localparam logic [2:0] MUL = 3'd7;

    logic         i_clk;
    logic         i_rsn;
    logic         i_valid;
    logic         o_ready;
    logic [2:0]   i_oper;
    logic [M-1:0] i_argA;
    logic [M-1:0] i_argB;
    logic         o_valid;
    logic         i_ready;
    logic [M-1:0] o_result;
    logic [3:0]   o_status;

    int total;
    int bad;

    typedef struct {
        logic [2:0]   op;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] res;
        logic [3:0]   st;
    } vec_t;

    vec_t vecs [16];

    exe_unit_w2 #(.m(M), .n(3)) dut (
        .i_clk    (i_clk),
        .i_rsn    (i_rsn),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_oper   (i_oper),
        .i_argA   (i_argA),
        .i_argB   (i_argB),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_status (o_status)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [M-1:0] a,
                         input logic [M-1:0] b, input logic rdy);
        i_valid = v;
        i_oper  = op;
        i_argA  = a;
        i_argB  = b;
        i_ready = rdy;
    endtask

    // Called at a negedge with the request already driven; junk is driven while waiting.
    task automatic run_vec(input string name, input vec_t v);
        int lat;
        int exp_lat;
        exp_lat = (MUL_ON && (v.op == MUL)) ? M + 1 : 1;
        @(posedge i_clk);
        @(negedge i_clk);
        drive(1'b1, ADD, ~v.a, ~v.b, 1'b0);
        lat = 1;
        while (!o_valid && lat < 40) begin
            check($sformatf("%s_busy_ready", name), o_ready, 0);
            @(negedge i_clk);
            lat++;
        end
        check($sformatf("%s_latency", name), lat, exp_lat);
        check($sformatf("%s_result", name), o_result, v.res);
        check($sformatf("%s_status", name), o_status, v.st);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{ADD, 8'h7F, 8'h01, 8'h80, 4'b0110};
        vecs[1]  = '{ADD, 8'hFF, 8'h01, 8'h00, 4'b0001};
        vecs[2]  = '{ADD, 8'h80, 8'h80, 8'h00, 4'b0101};
        vecs[3]  = '{SUB, 8'h05, 8'h05, 8'h00, 4'b0001};
        vecs[4]  = '{SUB, 8'h80, 8'h01, 8'h7F, 4'b0100};
        vecs[5]  = '{SUB, 8'h00, 8'h01, 8'hFF, 4'b0010};
        vecs[6]  = '{AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[7]  = '{OR,  8'h00, 8'h00, 8'h00, 4'b0001};
        vecs[8]  = '{XOR, 8'hF0, 8'hFF, 8'h0F, 4'b0000};
        vecs[9]  = '{SHL, 8'h81, 8'h09, 8'h02, 4'b0000};
        vecs[10] = '{SHL, 8'h01, 8'h07, 8'h80, 4'b0010};
        vecs[11] = '{SLT, 8'hFF, 8'h01, 8'h01, 4'b0000};
        vecs[12] = '{SLT, 8'h01, 8'hFF, 8'h00, 4'b0001};
        vecs[13] = '{SLT, 8'h80, 8'h7F, 8'h01, 4'b0000};
`ifdef EXE_UNIT_W2_MUL_EN
        vecs[14] = '{MUL, 8'h10, 8'h11, 8'h10, 4'b0100};
        vecs[15] = '{MUL, 8'h0F, 8'h0F, 8'hE1, 4'b0010};
`else
        vecs[14] = '{MUL, 8'h10, 8'h11, 8'h00, 4'b1001};
        vecs[15] = '{MUL, 8'h0F, 8'h0F, 8'h00, 4'b1001};
`endif

        // Reset state
        i_rsn = 1'b0;
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_result", o_result, 0);
        check("rst_status", o_status, 0);

        // First edge after release accepts SUB; result then holds while i_ready=0
        i_rsn = 1'b1;
        drive(1'b1, SUB, 8'h05, 8'h05, 1'b0);
        #1 check("sub_ready", o_ready, 1);
        @(posedge i_clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            drive(1'b1, ADD, 8'hFF, 8'hFF, 1'b0);
            check($sformatf("hold%0d_valid", k), o_valid, 1);
            check($sformatf("hold%0d_result", k), o_result, 8'h00);
            check($sformatf("hold%0d_status", k), o_status, 4'b0001);
            check($sformatf("hold%0d_ready", k), o_ready, 0);
        end

        // Back-to-back XOR out of DONE
        drive(1'b1, XOR, 8'hF0, 8'hFF, 1'b1);
        #1 check("b2b_ready", o_ready, 1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("b2b_valid", o_valid, 1);
        check("b2b_result", o_result, 8'h0F);
        check("b2b_status", o_status, 4'b0000);

        // DONE -> IDLE keeps last result
        drive(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("idle_valid", o_valid, 0);
        check("idle_ready", o_ready, 1);
        check("idle_result", o_result, 8'h0F);
        check("idle_status", o_status, 4'b0000);

        // Reset during the 4th BUSY cycle of a MUL
        drive(1'b1, MUL, 8'h10, 8'h11, 1'b0);
        @(posedge i_clk);
        repeat (4) begin
            @(negedge i_clk);
            drive(1'b1, ADD, 8'h01, 8'h01, 1'b0);
        end
        check("abort_pre_valid", o_valid, MUL_ON ? 0 : 1);
        check("abort_pre_result", o_result, MUL_ON ? 8'h0F : 8'h00);
        i_rsn = 1'b0;
        #1;
        check("abort_valid", o_valid, 0);
        check("abort_result", o_result, 0);
        check("abort_status", o_status, 0);
        check("abort_ready", o_ready, 1);
        @(negedge i_clk);
        check("abort_still_idle", o_valid, 0);

        i_rsn = 1'b1;
        drive(1'b1, SLT, 8'hFF, 8'h01, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("slt_valid", o_valid, 1);
        check("slt_result", o_result, 8'h01);
        check("slt_status", o_status, 4'b0000);

        // Vector table, each request issued back-to-back out of the previous DONE
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            #1 check($sformatf("v%0d_accept_ready", i), o_ready, 1);
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        drive(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        check("end_valid", o_valid, 0);
        check("end_result", o_result, vecs[15].res);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
